// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU pushes bytes into a TX FIFO and polls
// status; a bit-timing FSM shifts each byte out on txd, LSB first.
module uart_tx_mmio #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd867
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic [31:0] a,
   input  logic [31:0] di,
   input  logic [3:0]  m,
   input  logic        we,
   output logic [31:0] dout,
   output logic        txd,
   output logic        irq
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr, rdPtr;
   logic [CNT_W-1:0] count;
   logic             overflow, enable, irqEn;
   logic [15:0]      divisor;
   logic [1:0]       state;
   logic [15:0]      baudCnt;
   logic [2:0]       bitIdx;
   logic [7:0]       shift;

   logic wrSel, pushReq, pop, pushOk, empty, full, busy;
   logic unusedBits;

   assign wrSel   = sel & we;
   assign pushReq = wrSel && (a[3:2] == 2'd0) && m[0];
   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign busy    = (state != IDLE);
   assign pop     = (state == IDLE) && enable && !empty;
   // A pop in the same edge frees the slot, so a push into a full FIFO still fits.
   assign pushOk  = pushReq && (!full || pop);
   assign irq     = irqEn & empty & ~busy;

   assign unusedBits = ^{a[31:4], a[1:0], di[31:16], m[3:2]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (pushOk)
            wrPtr <= wrPtr + 1'b1;
         if (pop)
            rdPtr <= rdPtr + 1'b1;
         case ({pushOk, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (pushReq && full && !pop)
            overflow <= 1'b1;
         else if (wrSel && (a[3:2] == 2'd1) && m[0] && di[3])
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (pushOk)
         mem[wrPtr] <= di[7:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         divisor <= DIV_RESET;
         enable  <= 1'b0;
         irqEn   <= 1'b0;
      end else if (wrSel) begin
         if (a[3:2] == 2'd2) begin
            if (m[0])
               divisor[7:0] <= di[7:0];
            if (m[1])
               divisor[15:8] <= di[15:8];
         end
         if (a[3:2] == 2'd3 && m[0]) begin
            enable <= di[0];
            irqEn  <= di[1];
         end
      end
   end

   // txd is registered and updated on the same edge as each state change.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         baudCnt <= '0;
         bitIdx  <= '0;
         shift   <= '0;
         txd     <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               txd <= 1'b1;
               if (pop) begin
                  shift   <= mem[rdPtr];
                  baudCnt <= divisor;
                  state   <= START;
                  txd     <= 1'b0;
               end
            end
            START: begin
               if (baudCnt == '0) begin
                  baudCnt <= divisor;
                  bitIdx  <= '0;
                  state   <= DATA;
                  txd     <= shift[0];
               end else begin
                  baudCnt <= baudCnt - 1'b1;
               end
            end
            DATA: begin
               if (baudCnt == '0) begin
                  baudCnt <= divisor;
                  if (bitIdx == 3'd7) begin
                     state <= STOP;
                     txd   <= 1'b1;
                  end else begin
                     bitIdx <= bitIdx + 3'd1;
                     shift  <= {1'b0, shift[7:1]};
                     txd    <= shift[1];
                  end
               end else begin
                  baudCnt <= baudCnt - 1'b1;
               end
            end
            default: begin
               if (baudCnt == '0) begin
                  baudCnt <= divisor;
                  state   <= IDLE;
               end else begin
                  baudCnt <= baudCnt - 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      dout = '0;
      if (sel) begin
         case (a[3:2])
            2'd1:    dout = {16'b0, 8'(count), 4'b0, overflow, busy, full, empty};
            2'd2:    dout = {16'b0, divisor};
            2'd3:    dout = {30'b0, irqEn, enable};
            default: dout = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: register vectors, exact frame timing,
// FIFO overflow/wrap corners, and randomized pushes checked by a serial receiver.
module tb_uart_tx_mmio;

   logic        clk = 1'b0;
   logic        reset, sel, we;
   logic [31:0] a, di, dout;
   logic [3:0]  m;
   logic        txd, irq;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] modelDiv = 16'd867;
   bit          rxOn = 1'b0;
   logic        prevTxd = 1'b1;
   logic [7:0]  rxQ[$];
   logic [7:0]  expQ[$];

   typedef struct {
      logic [1:0]  wAddr;
      logic [3:0]  wMask;
      logic [31:0] wData;
      logic        wSel;
      logic [1:0]  rAddr;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [1:0]  addr;
      logic        selV;
      logic [31:0] exp;
   } rdVec_t;

   uart_tx_mmio #(.FIFO_DEPTH(8), .DIV_RESET(16'd867)) dut (
      .clk(clk), .reset(reset), .sel(sel), .a(a), .di(di), .m(m), .we(we),
      .dout(dout), .txd(txd), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One bus write, committed at the next rising edge; returns 1ns after it.
   task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data,
                                input logic [3:0] mask, input logic selV);
      @(negedge clk);
      a = $urandom;
      a[3:2] = addr;
      di = data;
      m = mask;
      sel = selV;
      we = 1'b1;
      @(posedge clk);
      #1;
      sel = 1'b0;
      we = 1'b0;
      m = 4'b0;
      if (selV && addr == 2'd2) begin
         if (mask[0]) modelDiv[7:0] = data[7:0];
         if (mask[1]) modelDiv[15:8] = data[15:8];
      end
   endtask

   task automatic readReg(input logic [1:0] addr, input logic selV, output logic [31:0] data);
      @(negedge clk);
      a = $urandom;
      a[3:2] = addr;
      sel = selV;
      we = 1'b0;
      #1;
      data = dout;
      sel = 1'b0;
   endtask

   task automatic readCheck(input string name, input logic [1:0] addr, input logic [31:0] exp);
      logic [31:0] v;
      readReg(addr, 1'b1, v);
      checkOutput(name, v, exp);
   endtask

   task automatic checkRx(input string name);
      int budget;
      int waited;
      budget = expQ.size() * (10 * (int'(modelDiv) + 1) + 2) + 50;
      waited = 0;
      while (rxQ.size() < expQ.size() && waited < budget) begin
         @(posedge clk);
         waited++;
      end
      if (rxQ.size() < expQ.size()) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s timeout: got %0d bytes expected %0d", name, rxQ.size(), expQ.size());
      end
      while (rxQ.size() > 0 && expQ.size() > 0)
         checkOutput(name, {24'b0, rxQ.pop_front()}, {24'b0, expQ.pop_front()});
      rxQ.delete();
      expQ.delete();
   endtask

   // Behavioural 8N1 receiver: sample mid-bit using the divisor the bench last wrote.
   initial begin
      int bitLen;
      logic [7:0] b;
      forever begin
         @(posedge clk);
         #1;
         if (rxOn && prevTxd === 1'b1 && txd === 1'b0) begin
            bitLen = int'(modelDiv) + 1;
            for (int i = 0; i < bitLen / 2; i++) begin
               @(posedge clk);
               #1;
            end
            checkOutput("rxStartBit", {31'b0, txd}, 32'd0);
            for (int k = 0; k < 8; k++) begin
               for (int i = 0; i < bitLen; i++) begin
                  @(posedge clk);
                  #1;
               end
               b[k] = txd;
            end
            for (int i = 0; i < bitLen; i++) begin
               @(posedge clk);
               #1;
            end
            checkOutput("rxStopBit", {31'b0, txd}, 32'd1);
            rxQ.push_back(b);
         end
         prevTxd = txd;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t        vecs[11];
      rdVec_t      rds[6];
      logic [31:0] v;
      logic [7:0]  pend[$];
      logic        modelOv;
      logic [7:0]  frameByte;
      logic        expBit;
      int          j, n;
      logic        s;
      logic [3:0]  mk;
      logic [7:0]  rb;

      rds[0] = '{2'd1, 1'b1, 32'h0000_0001};
      rds[1] = '{2'd2, 1'b1, 32'd867};
      rds[2] = '{2'd3, 1'b1, 32'h0};
      rds[3] = '{2'd0, 1'b1, 32'h0};
      rds[4] = '{2'd1, 1'b0, 32'h0};
      rds[5] = '{2'd2, 1'b0, 32'h0};

      vecs[0]  = '{2'd2, 4'b0001, 32'h1234_5607, 1'b1, 2'd2, 32'h0000_0307};
      vecs[1]  = '{2'd2, 4'b0010, 32'h0000_AB00, 1'b1, 2'd2, 32'h0000_AB07};
      vecs[2]  = '{2'd2, 4'b0011, 32'hFFFF_0003, 1'b1, 2'd2, 32'h0000_0003};
      vecs[3]  = '{2'd2, 4'b0000, 32'h0000_0055, 1'b1, 2'd2, 32'h0000_0003};
      vecs[4]  = '{2'd2, 4'b0001, 32'h0000_0077, 1'b0, 2'd2, 32'h0000_0003};
      vecs[5]  = '{2'd3, 4'b0001, 32'h0000_0003, 1'b1, 2'd3, 32'h0000_0003};
      vecs[6]  = '{2'd3, 4'b1110, 32'h0000_0000, 1'b1, 2'd3, 32'h0000_0003};
      vecs[7]  = '{2'd3, 4'b0001, 32'h0000_0000, 1'b1, 2'd3, 32'h0000_0000};
      vecs[8]  = '{2'd1, 4'b0001, 32'h0000_0008, 1'b1, 2'd1, 32'h0000_0001};
      vecs[9]  = '{2'd0, 4'b0000, 32'h0000_00AA, 1'b1, 2'd1, 32'h0000_0001};
      vecs[10] = '{2'd0, 4'b0001, 32'h0000_00BB, 1'b0, 2'd1, 32'h0000_0001};

      sel = 1'b0; we = 1'b0; a = '0; di = '0; m = '0;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      $display("[TB] reset state and register table");
      for (int i = 0; i < 6; i++) begin
         readReg(rds[i].addr, rds[i].selV, v);
         checkOutput($sformatf("resetRead%0d", i), v, rds[i].exp);
      end
      checkOutput("resetTxd", {31'b0, txd}, 32'd1);
      checkOutput("resetIrq", {31'b0, irq}, 32'd0);
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].wAddr, vecs[i].wData, vecs[i].wMask, vecs[i].wSel);
         readCheck($sformatf("vec%0d", i), vecs[i].rAddr, vecs[i].exp);
      end

      $display("[TB] exact frame timing, DIVISOR=3, byte 0xA5");
      applyStimulus(2'd2, 32'd3, 4'b0011, 1'b1);
      applyStimulus(2'd3, 32'd1, 4'b0001, 1'b1);
      rxOn = 1'b1;
      frameByte = 8'hA5;
      applyStimulus(2'd0, {24'b0, frameByte}, 4'b0001, 1'b1);
      expQ.push_back(frameByte);
      checkOutput("txdBeforePop", {31'b0, txd}, 32'd1);
      sel = 1'b1; a = 32'h4; we = 1'b0;
      for (int k = 1; k <= 41; k++) begin
         @(posedge clk);
         #1;
         j = (k - 1) / 4;
         if (k > 40 || j == 9) expBit = 1'b1;
         else if (j == 0)      expBit = 1'b0;
         else                  expBit = frameByte[j-1];
         checkOutput($sformatf("frameTxd%0d", k), {31'b0, txd}, {31'b0, expBit});
         checkOutput($sformatf("frameBusy%0d", k), {31'b0, dout[2]}, {31'b0, k <= 40});
      end
      sel = 1'b0;
      checkRx("rxA5");

      $display("[TB] overflow with enable off, then drain");
      applyStimulus(2'd3, 32'd0, 4'b0001, 1'b1);
      for (int i = 0; i < 9; i++) begin
         applyStimulus(2'd0, i, 4'b0001, 1'b1);
         if (i < 8) expQ.push_back(8'(i));
      end
      readCheck("statusFullOv", 2'd1, 32'h0000_080A);
      applyStimulus(2'd3, 32'd1, 4'b0001, 1'b1);
      checkRx("rxOverflowDrain");
      repeat (10) @(posedge clk);
      readCheck("statusOvSticky", 2'd1, 32'h0000_0009);
      applyStimulus(2'd1, 32'h8, 4'b0001, 1'b1);
      readCheck("statusOvCleared", 2'd1, 32'h0000_0001);

      $display("[TB] push into full FIFO on the pop edge");
      applyStimulus(2'd3, 32'd0, 4'b0001, 1'b1);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(2'd0, 32'h10 + i, 4'b0001, 1'b1);
         expQ.push_back(8'(8'h10 + i));
      end
      applyStimulus(2'd3, 32'd1, 4'b0001, 1'b1);
      applyStimulus(2'd0, 32'h18, 4'b0001, 1'b1);
      expQ.push_back(8'h18);
      readCheck("statusPushOnPop", 2'd1, 32'h0000_0806);
      checkRx("rxWrap");

      $display("[TB] randomized push sequences");
      for (int r = 0; r < 3; r++) begin
         repeat (20) @(posedge clk);
         applyStimulus(2'd3, 32'd0, 4'b0001, 1'b1);
         applyStimulus(2'd2, $urandom_range(0, 3), 4'b0011, 1'b1);
         pend.delete();
         modelOv = 1'b0;
         n = $urandom_range(4, 11);
         for (int i = 0; i < n; i++) begin
            s  = ($urandom_range(0, 3) != 0);
            mk = 4'($urandom);
            rb = 8'($urandom);
            applyStimulus(2'd0, {$urandom, rb} & 32'h0000_FFFF | {24'b0, rb}, mk, s);
            if (s && mk[0]) begin
               if (pend.size() < 8) pend.push_back(rb);
               else modelOv = 1'b1;
            end
         end
         readCheck($sformatf("randStatus%0d", r), 2'd1,
                   {16'b0, 8'(pend.size()), 4'b0, modelOv, 1'b0,
                    pend.size() == 8, pend.size() == 0});
         foreach (pend[i]) expQ.push_back(pend[i]);
         applyStimulus(2'd3, 32'd1, 4'b0001, 1'b1);
         checkRx($sformatf("rxRandom%0d", r));
         applyStimulus(2'd1, 32'h8, 4'b0001, 1'b1);
      end

      $display("[TB] interrupt around two frames, DIVISOR=1");
      repeat (20) @(posedge clk);
      applyStimulus(2'd2, 32'd1, 4'b0011, 1'b1);
      applyStimulus(2'd3, 32'd3, 4'b0001, 1'b1);
      checkOutput("irqIdleEmpty", {31'b0, irq}, 32'd1);
      applyStimulus(2'd0, 32'h3C, 4'b0001, 1'b1);
      checkOutput("irqAfterPush", {31'b0, irq}, 32'd0);
      applyStimulus(2'd0, 32'hC3, 4'b0001, 1'b1);
      expQ.push_back(8'h3C);
      expQ.push_back(8'hC3);
      checkOutput("irqFrame1", {31'b0, irq}, 32'd0);
      for (int k = 2; k <= 42; k++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("irqFrame%0d", k), {31'b0, irq}, {31'b0, k == 42});
      end
      checkRx("rxIrqFrames");

      $display("[TB] reset asserted mid-frame");
      repeat (10) @(posedge clk);
      rxOn = 1'b0;
      applyStimulus(2'd0, 32'h00, 4'b0001, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("txdMidFrame", {31'b0, txd}, 32'd0);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("txdInReset", {31'b0, txd}, 32'd1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      modelDiv = 16'd867;
      readCheck("statusAfterReset", 2'd1, 32'h0000_0001);
      readCheck("divAfterReset", 2'd2, 32'd867);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("txdAfterReset", {31'b0, txd}, 32'd1);
      checkOutput("irqAfterReset", {31'b0, irq}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter that acts as a responder on the CPU data bus: address, write data, read data, byte write mask and write enable.
- External address decode asserts `sel`. The CPU pushes bytes into a TX FIFO and polls status.
- A bit-timing FSM serialises each byte as 8N1 on `txd`.
- Sits beside the RAM on the data bus; `txd` goes to the board pin.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, minimum 2.
- DIV_RESET, 867, reset value of DIVISOR (clocks per bit minus 1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- sel  in  1  block selected by external decode; qualifies `we` and read data.
- a  in  32  byte address; only a[3:2] decoded.
- di  in  32  write data.
- m  in  4  byte write mask; m[i] enables byte i.
- we  in  1  write enable.
- do  out  32  read data, combinational from a[3:2]; 0 when sel=0.
- txd  out  1  serial output, idle high.
- irq  out  1  level interrupt.

Behaviour:
- Register map (a[3:2]):
  - 0 TXDATA: write with m[0]=1 pushes di[7:0]. Reads 0.
  - 1 STATUS (read): [0] empty, [1] full, [2] busy (FSM not IDLE), [3] overflow (sticky), [15:8] FIFO count, rest 0. Write with m[0]=1 and di[3]=1 clears overflow.
  - 2 DIVISOR: [15:0], bytes written per m[1:0]; upper bits read 0. Value 0 is legal (1 clock per bit).
  - 3 CTRL: [0] enable, [1] irqEn; written when m[0]=1.
- Writes take effect at the rising edge where sel=we=1. Writes with sel=0 or the relevant mask bit 0 are ignored.
- Reset values: txd=1, irq=0, FIFO empty (count 0), overflow=0, enable=0, irqEn=0, DIVISOR=DIV_RESET, FSM=IDLE, baud counter 0.
- Reset asserted mid-frame aborts the frame immediately; txd=1 and the FIFO is flushed.
- FIFO:
  - Circular read/write pointers with wrap-around at FIFO_DEPTH; count has width log2(FIFO_DEPTH)+1.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle (count unchanged).
  - A push to a full FIFO with no pop is dropped and sets overflow. FIFO contents are unchanged.
  - A push and a pop together when not full: count unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if enable=1 and FIFO not empty, pop into shift register, load baud counter with DIVISOR, go to START. txd=0 from the following cycle.
  - START: txd=0 for DIVISOR+1 cycles, then DATA with bit index 0.
  - DATA: txd=shift[0], LSB first. Each bit lasts DIVISOR+1 cycles. After bit 7, go to STOP.
  - STOP: txd=1 for DIVISOR+1 cycles, then IDLE.
  - Frame is 10*(DIVISOR+1) cycles. Back-to-back frames are separated by exactly one IDLE cycle.
- Baud counter:
  - Counts down to 0; at 0, reloads from the DIVISOR register and advances the bit.
  - A DIVISOR write mid-frame affects bit periods from the next reload.
- Clearing enable mid-frame completes the current frame. No further pops occur while enable=0.
- Latency: TXDATA write accepted at edge N into an empty FIFO with FSM in IDLE and enable=1 → pop at edge N+1 → txd low after edge N+1.
- irq = irqEn & empty & ~busy (combinational from registered state).

Test Plan:
- Reset, then read STATUS → 0x00000001. Read DIVISOR → 867. txd=1, irq=0.
- DIVISOR=3, CTRL=1, write TXDATA 0xA5 → txd sampled every 4 cycles reads 0,1,0,1,0,0,1,0,1,1. Falls 1 cycle after the write edge. busy high for 40 cycles.
- CTRL=0, push 9 bytes (0x00..0x08) with FIFO_DEPTH=8 → STATUS full=1, count=8, overflow=1. Set CTRL=1 → bytes 0x00..0x07 sent in order, 0x08 lost. Write STATUS di=0x8 → overflow=0.
- Write TXDATA with m=4'b0000, then with sel=0 → no push, STATUS count unchanged. Write DIVISOR m=4'b0001 di=0x12345607 → DIVISOR=0x0307 (from 0x0363).
- FIFO full with the FSM popping at the same edge as a TXDATA write → write accepted, count stays 8, overflow=0. Verify transmitted order across pointer wrap-around.
- DIVISOR=1, CTRL=3, send 2 bytes → irq=0 during transmission, irq=1 one cycle after the final STOP ends. Assert reset mid-frame → txd=1 and STATUS=0x1 after release.
